position_sequencer: RTL

Parametrised three-level position sequencer (channel → column → row) for the convolution datapath. It is the generalised successor of the fixed free-running 2-bit channel counter. It adds run-time terminal counts, an advance enable for stalls, a start/done handshake, single-shot or continuous frame mode, and abort. It sits between the layer controller (start/config) and the line-buffer/MAC address generators, which consume the (ch, col, row) indices.

---
 rtl/position_sequencer_if.sv | 34 +++
 rtl/position_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/position_sequencer_if.sv
// Bus between the layer controller and the position sequencer: frame control,
// run-time terminal counts, and the (ch, col, row) index stream with its flags.
interface position_sequencer_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 10
);
    logic             start;
    logic             cont;
    logic             abort;
    logic             en;
    logic [CH_W-1:0]  cfg_ch_last;
    logic [COL_W-1:0] cfg_col_last;
    logic [ROW_W-1:0] cfg_row_last;
    logic [CH_W-1:0]  ch;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             valid;
    logic             busy;
    logic             last_ch;
    logic             last_col;
    logic             last_pos;
    logic             done;

    modport master (
        output start, cont, abort, en, cfg_ch_last, cfg_col_last, cfg_row_last,
        input  ch, col, row, valid, busy, last_ch, last_col, last_pos, done
    );

    modport slave (
        input  start, cont, abort, en, cfg_ch_last, cfg_col_last, cfg_row_last,
        output ch, col, row, valid, busy, last_ch, last_col, last_pos, done
    );
endinterface

// File: rtl/position_sequencer.sv
// Three-level (channel -> column -> row) position sequencer with run-time
// terminal counts, stall enable, single-shot/continuous frames and abort.
module position_sequencer #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    position_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CH_W-1:0]  r_ch;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [CH_W-1:0]  r_ch_last;
    logic [COL_W-1:0] r_col_last;
    logic [ROW_W-1:0] r_row_last;
    logic             r_cont;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic w_ch_wrap;
    logic w_col_wrap;
    logic w_final;

    // Wrap conditions chain inward: col only wraps on a channel wrap, etc.
    assign w_ch_wrap  = (r_ch == r_ch_last);
    assign w_col_wrap = w_ch_wrap & (r_col == r_col_last);
    assign w_final    = w_col_wrap & (r_row == r_row_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_ch_last  <= '0;
            r_col_last <= '0;
            r_row_last <= '0;
            r_cont     <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ch_last  <= bus.cfg_ch_last;
                        r_col_last <= bus.cfg_col_last;
                        r_row_last <= bus.cfg_row_last;
                        r_cont     <= bus.cont;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_ch    <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (bus.en) begin
                        if (w_final) begin
                            // Frame complete: rewind; continuous mode keeps running
                            r_ch   <= '0;
                            r_col  <= '0;
                            r_row  <= '0;
                            r_done <= 1'b1;
                            if (!r_cont) begin
                                r_valid <= 1'b0;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_ch <= w_ch_wrap ? '0 : r_ch + CH_W'(1);
                            if (w_ch_wrap) begin
                                r_col <= w_col_wrap ? '0 : r_col + COL_W'(1);
                            end
                            if (w_col_wrap) begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ch    <= '0;
                    r_col   <= '0;
                    r_row   <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ch       = r_ch;
    assign bus.col      = r_col;
    assign bus.row      = r_row;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.last_ch  = r_valid & w_ch_wrap;
    assign bus.last_col = r_valid & w_col_wrap;
    assign bus.last_pos = r_valid & w_final;

endmodule
